stream_rr_arb: RTL and testbench

Round-robin arbiter that merges N valid/ready request streams into one registered output stream. It is the standard front end for a shared downstream resource such as a queue instance or a CXU request port. It grants at most one requester per cycle, registers the winning item together with its requester index, and advances a rotating priority pointer so that no continuously-valid requester starves. An optional packet-lock mode holds the grant across multi-beat transfers.

---
 rtl/common_pkg.sv | 14 +
 rtl/rr_pick.sv | 36 +++
 rtl/stream_rr_arb.sv | 160 ++++++++++++++++
 tb/tb_stream_rr_arb.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared arbitration types and elaboration-time parameter helpers.
package common_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // True when a size parameter is usable (strictly positive).
    function automatic bit check_param_pos(input int v);
        return v > 0;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: returns the first asserted req at or above
// prio, wrapping from N-1 back to 0. Purely combinational.
module rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] prio,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        sum  = '0;
        cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, prio} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            cand = sum[IW-1:0];
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/stream_rr_arb.sv
// Round-robin merge of N valid/ready streams into one registered output.
// Define STREAM_RR_ARB_LOCK_EN to hold the grant until i_last closes a
// multi-beat packet; otherwise every beat is arbitrated on its own.
module stream_rr_arb
    import common_pkg::*;
#(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic [N-1:0]         i_valid,
    output logic [N-1:0]         i_ready,
    input  logic [N*W-1:0]       i,
    input  logic [N-1:0]         i_last,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [W-1:0]         o,
    output logic [$clog2(N)-1:0] o_id,
    output logic                 o_last
);

    localparam int IW = $clog2(N);
    typedef logic [IW-1:0] id_t;

    if (!check_param_pos(W) || N < 2) begin : g_param_err
        $error("stream_rr_arb: requires N >= 2 and W >= 1");
    end

    logic         o_valid_q, o_valid_d;
    logic [W-1:0] o_q, o_d;
    id_t          o_id_q, o_id_d;
    logic         o_last_q, o_last_d;
    id_t          prio_q, prio_d;

    logic [N-1:0] req;
    logic         any;
    id_t          win;
    logic         stage_free;
    logic         xfer;
    logic         adv;
    logic [W-1:0] win_data;
    id_t          nxt_prio;

    rr_pick #(.N(N)) u_pick (
        .req  (req),
        .prio (prio_q),
        .any  (any),
        .idx  (win)
    );

`ifdef STREAM_RR_ARB_LOCK_EN
    arb_state_t   st_q, st_d;
    id_t          owner_q, owner_d;
    logic [N-1:0] owner_mask;

    // While locked, only the packet owner may compete.
    always_comb begin
        owner_mask          = '0;
        owner_mask[owner_q] = 1'b1;
        req = (st_q == ARB_LOCKED) ? (i_valid & owner_mask) : i_valid;
    end

    // Lock FSM: open a lock on a non-last beat, release on the last one.
    always_comb begin
        st_d    = st_q;
        owner_d = owner_q;
        adv     = 1'b1;
        if (xfer) begin
            if (!i_last[win]) begin
                st_d    = ARB_LOCKED;
                owner_d = win;
                adv     = 1'b0;
            end else begin
                st_d    = ARB_IDLE;
            end
        end
    end

    // Lock state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= ARB_IDLE;
            owner_q <= '0;
        end else begin
            st_q    <= st_d;
            owner_q <= owner_d;
        end
    end
`else
    assign req = i_valid;
    assign adv = 1'b1;
`endif

    assign stage_free = !o_valid_q || o_ready;
    assign xfer       = clk_en && stage_free && any;
    assign nxt_prio   = (win == id_t'(N - 1)) ? '0 : id_t'(win + 1'b1);

    // One-hot ready to the winner; winner is always a valid requester.
    always_comb begin
        i_ready = '0;
        if (xfer) begin
            i_ready[win] = 1'b1;
        end
    end

    // Select the winner's data slice.
    always_comb begin
        win_data = '0;
        for (int k = 0; k < N; k++) begin
            if (win == id_t'(k)) begin
                win_data = i[k*W +: W];
            end
        end
    end

    // Output stage and priority next-state; clk_en=0 falls through to hold.
    always_comb begin
        o_valid_d = o_valid_q;
        o_d       = o_q;
        o_id_d    = o_id_q;
        o_last_d  = o_last_q;
        prio_d    = prio_q;
        if (xfer) begin
            o_valid_d = 1'b1;
            o_d       = win_data;
            o_id_d    = win;
            o_last_d  = i_last[win];
            if (adv) begin
                prio_d = nxt_prio;
            end
        end else if (clk_en && o_ready) begin
            o_valid_d = 1'b0;
        end
    end

    // Output register and priority pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid_q <= 1'b0;
            o_q       <= '0;
            o_id_q    <= '0;
            o_last_q  <= 1'b0;
            prio_q    <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_q       <= o_d;
            o_id_q    <= o_id_d;
            o_last_q  <= o_last_d;
            prio_q    <= prio_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o       = o_q;
    assign o_id    = o_id_q;
    assign o_last  = o_last_q;

endmodule

// File: tb/tb_stream_rr_arb.sv
// Directed bench for stream_rr_arb: an N=4/W=8 instance plus an N=3
// instance for non-power-of-2 wrap. Lock behaviour follows
// STREAM_RR_ARB_LOCK_EN.
module tb_stream_rr_arb;

    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    logic o_ready;

    logic [3:0]  v4, l4, r4;
    logic [31:0] d4;
    logic        ov4, ol4;
    logic [7:0]  o4;
    logic [1:0]  oid4;

    logic [2:0]  v3, l3, r3;
    logic [23:0] d3;
    logic        ov3, ol3;
    logic [7:0]  o3;
    logic [1:0]  oid3;

    int total  = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    stream_rr_arb #(.N(4), .W(8)) u_dut4 (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .i_valid(v4), .i_ready(r4), .i(d4), .i_last(l4),
        .o_valid(ov4), .o_ready(o_ready), .o(o4), .o_id(oid4), .o_last(ol4)
    );

    stream_rr_arb #(.N(3), .W(8)) u_dut3 (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .i_valid(v3), .i_ready(r3), .i(d3), .i_last(l3),
        .o_valid(ov3), .o_ready(o_ready), .o(o3), .o_id(oid3), .o_last(ol3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect a grant to id with data dat on the next edge.
    task automatic grant4(input string tag, input logic [1:0] id, input logic [7:0] dat,
                          input logic last);
        #1;
        chk({tag, "_rdy"}, {28'd0, r4}, 32'(4'b0001 << id));
        step();
        chk({tag, "_vld"}, {31'd0, ov4}, 32'd1);
        chk({tag, "_id"},  {30'd0, oid4}, {30'd0, id});
        chk({tag, "_dat"}, {24'd0, o4}, {24'd0, dat});
        chk({tag, "_lst"}, {31'd0, ol4}, {31'd0, last});
    endtask

    task automatic grant3(input string tag, input logic [1:0] id, input logic [7:0] dat);
        #1;
        chk({tag, "_rdy"}, {29'd0, r3}, 32'(3'b001 << id));
        step();
        chk({tag, "_vld"}, {31'd0, ov3}, 32'd1);
        chk({tag, "_id"},  {30'd0, oid3}, {30'd0, id});
        chk({tag, "_dat"}, {24'd0, o3}, {24'd0, dat});
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; o_ready = 1'b1;
        v4 = '0; l4 = 4'b1111; d4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        v3 = '0; l3 = 3'b111;  d3 = {8'hB2, 8'hB1, 8'hB0};
        step();
        chk("rst_vld",  {31'd0, ov4}, 32'd0);
        chk("rst_id",   {30'd0, oid4}, 32'd0);
        chk("rst_dat",  {24'd0, o4}, 32'd0);
        chk("rst_last", {31'd0, ol4}, 32'd0);
        rst = 1'b0;

        // Fairness: all four valid, two full rounds, then one extra grant.
        v4 = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            grant4("fair", 2'(k % 4), 8'hA0 + 8'(k % 4), 1'b1);
        end
        grant4("fair_x", 2'd0, 8'hA0, 1'b1);

        // Asynchronous reset while o_valid=1; prio was 1 before reset.
        rst = 1'b1;
        #1;
        chk("arst_vld", {31'd0, ov4}, 32'd0);
        chk("arst_id",  {30'd0, oid4}, 32'd0);
        step();
        rst = 1'b0;
        grant4("post_rst", 2'd0, 8'hA0, 1'b1);

        // Backpressure: held output, no readies, then dequeue+accept.
        o_ready = 1'b0; v4 = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_rdy", {28'd0, r4}, 32'd0);
            step();
            chk("bp_vld", {31'd0, ov4}, 32'd1);
            chk("bp_dat", {24'd0, o4}, 32'hA0);
        end
        o_ready = 1'b1;
        grant4("bp_rel", 2'd1, 8'hA1, 1'b1);

        // clk_en low: nothing moves even with o_ready=1.
        clk_en = 1'b0; v4 = 4'b1111;
        #1;
        chk("ce_rdy", {28'd0, r4}, 32'd0);
        step();
        chk("ce_vld", {31'd0, ov4}, 32'd1);
        chk("ce_id",  {30'd0, oid4}, 32'd1);
        chk("ce_dat", {24'd0, o4}, 32'hA1);
        clk_en = 1'b1;
        grant4("ce_on", 2'd2, 8'hA2, 1'b1);

        // Gaps and wrap: prio=3 with 3 and 0 valid.
        v4 = 4'b1001;
        grant4("gap3", 2'd3, 8'hA3, 1'b1);
        v4 = 4'b0001;
        grant4("gap0", 2'd0, 8'hA0, 1'b1);
        v4 = 4'b0010;
        grant4("solo1", 2'd1, 8'hA1, 1'b1);
        v4 = 4'b1111;
        grant4("after1", 2'd2, 8'hA2, 1'b1);

        // Drain: no request, o_ready=1 -> o_valid drops, data held.
        v4 = '0;
        step();
        chk("drain_vld", {31'd0, ov4}, 32'd0);
        chk("drain_dat", {24'd0, o4}, 32'hA2);

        // Packet from requester 0 (3 beats) against single-beat requester 1; prio=3.
        v4 = 4'b0011; l4 = 4'b0010; d4 = {8'hA3, 8'hA2, 8'hA1, 8'hC1};
`ifdef STREAM_RR_ARB_LOCK_EN
        grant4("lk_b1", 2'd0, 8'hC1, 1'b0);
        d4[7:0] = 8'hC2;
        grant4("lk_b2", 2'd0, 8'hC2, 1'b0);
        d4[7:0] = 8'hC3; l4[0] = 1'b1;
        grant4("lk_b3", 2'd0, 8'hC3, 1'b1);
        v4 = 4'b0010;
        grant4("lk_r1", 2'd1, 8'hA1, 1'b1);
`else
        grant4("nl_b1", 2'd0, 8'hC1, 1'b0);
        d4[7:0] = 8'hC2;
        grant4("nl_r1", 2'd1, 8'hA1, 1'b1);
        v4 = 4'b0001;
        grant4("nl_b2", 2'd0, 8'hC2, 1'b0);
        d4[7:0] = 8'hC3; l4[0] = 1'b1;
        grant4("nl_b3", 2'd0, 8'hC3, 1'b1);
`endif
        v4 = '0;

        // N=3: wrap from 2 back to 0 must not pass through a phantom index 3.
        v3 = 3'b010;
        grant3("n3_solo1", 2'd1, 8'hB1);
        v3 = 3'b101;
        grant3("n3_g2", 2'd2, 8'hB2);
        grant3("n3_g0", 2'd0, 8'hB0);
        grant3("n3_g2b", 2'd2, 8'hB2);
        v3 = 3'b111;
        grant3("n3_f0", 2'd0, 8'hB0);
        grant3("n3_f1", 2'd1, 8'hB1);
        grant3("n3_f2", 2'd2, 8'hB2);
        grant3("n3_f0b", 2'd0, 8'hB0);
        v3 = '0;
        step();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
